// File: rtl/bcd_to_binary_if.sv
// Handshake bundle between a BCD-to-binary decoder and the block that requests conversions.
interface bcd_to_binary_if #(
  parameter int unsigned DIGITS    = 5,
  parameter int unsigned BIN_WIDTH = 17
);
  logic                   start;
  logic [4*DIGITS-1:0]    bcd_in;
  logic                   busy;
  logic                   done;
  logic [BIN_WIDTH-1:0]   bin_out;
  logic                   err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );
endinterface

// File: rtl/bcd_to_binary.sv
// Sequential BCD-to-binary decoder using reverse double-dabble, one shift per clock.
// Optional invalid-digit detection is enabled by defining BCD2BIN_DIGIT_CHECK_EN.
module bcd_to_binary #(
  parameter int unsigned DIGITS    = 5,
  parameter int unsigned BIN_WIDTH = 17
) (
  input logic            clk,
  input logic            reset,
  bcd_to_binary_if.slave bus
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [BcdW-1:0]      bcd_q, bcd_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BIN_WIDTH-1:0] bin_out_q, bin_out_d;
  logic                 done_q, done_d;
  logic [BcdW-1:0]      bcd_shift, bcd_fix;

  // One iteration: right shift, then pull every digit that became >= 8 back by 3.
  always_comb begin
    bcd_shift = bcd_q >> 1;
    bcd_fix   = bcd_shift;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_shift[4*i+3]) begin
        bcd_fix[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  logic inv_q, inv_d;
  logic err_q, err_d;
  logic bcd_in_bad;

  always_comb begin
    bcd_in_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) begin
        bcd_in_bad = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    done_d    = 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    inv_d     = inv_q;
    err_d     = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          bcd_d   = bus.bcd_in;
          bin_d   = '0;
          cnt_d   = CntW'(BIN_WIDTH);
          state_d = StShift;
`ifdef BCD2BIN_DIGIT_CHECK_EN
          inv_d   = bcd_in_bad;
`endif
        end
      end
      StShift: begin
        bcd_d = bcd_fix;
        bin_d = {bcd_q[0], bin_q[BIN_WIDTH-1:1]};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d    = 1'b1;
        state_d   = StIdle;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err_d     = inv_q;
        bin_out_d = inv_q ? '0 : bin_q;
`else
        bin_out_d = bin_q;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      done_q    <= done_d;
    end
  end

`ifdef BCD2BIN_DIGIT_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inv_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;
  assign bus.bin_out = bin_out_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed scenarios plus randomized conversions
// against a decimal-arithmetic reference model.
module tb_bcd_to_binary;

  localparam int unsigned DIGITS    = 5;
  localparam int unsigned BIN_WIDTH = 17;
  localparam int          LAT       = 18;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;

  bcd_to_binary_if #(.DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH)) bus ();

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_WIDTH(BIN_WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [BIN_WIDTH-1:0] ref_val(input logic [4*DIGITS-1:0] b);
    int unsigned v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return BIN_WIDTH'(v);
  endfunction

  function automatic logic [4*DIGITS-1:0] rand_bcd();
    logic [4*DIGITS-1:0] b;
    for (int i = 0; i < DIGITS; i++) b[4*i +: 4] = 4'($urandom_range(0, 9));
    return b;
  endfunction

  // Called at a negedge; start is sampled by the next posedge, returns at the following negedge.
  task automatic start_now(input logic [4*DIGITS-1:0] v);
    bus.start  = 1'b1;
    bus.bcd_in = v;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt, output int done_cyc);
    lat = -1;
    bcnt = 0;
    done_cyc = -1;
    if (bus.busy) bcnt++;
    for (int j = 1; j <= 100; j++) begin
      @(negedge clk);
      bus.bcd_in = rand_bcd();
      if (bus.done) begin
        lat = j;
        done_cyc = cyc;
        break;
      end
      if (bus.busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bin_out !== '0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b bin_out=%0d err=%b, want 0 0 0 0",
               bus.busy, bus.done, bus.bin_out, bus.err);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_zero;
    int lat, bcnt, dc;
    @(negedge clk);
    start_now('0);
    wait_done(lat, bcnt, dc);
    checks++;
    if (lat !== LAT) begin
      errors++;
      $display("FAIL zero_latency: got %0d, want %0d", lat, LAT);
    end
    checks++;
    if (bcnt !== LAT) begin
      errors++;
      $display("FAIL zero_busy_cycles: got %0d, want %0d", bcnt, LAT);
    end
    checks++;
    if (bus.bin_out !== '0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL zero_result: bin_out=%0d err=%b, want 0 0", bus.bin_out, bus.err);
    end
  endtask

  task automatic test_nines;
    int lat, bcnt, dc;
    @(negedge clk);
    start_now(20'h99999);
    wait_done(lat, bcnt, dc);
    checks++;
    if (lat !== LAT || bus.bin_out !== 17'h1869F) begin
      errors++;
      $display("FAIL nines_result: lat=%0d bin_out=%h, want %0d 1869f", lat, bus.bin_out, LAT);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL nines_done_pulse: done=%b busy=%b one cycle later, want 0 0",
               bus.done, bus.busy);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (bus.bin_out !== 17'h1869F) begin
      errors++;
      $display("FAIL nines_hold: bin_out=%h, want 1869f", bus.bin_out);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bcnt, dc, extra;
    @(negedge clk);
    start_now(20'h12345);
    repeat (4) @(negedge clk);
    start_now(20'h00001);
    wait_done(lat, bcnt, dc);
    checks++;
    if (lat !== LAT - 5 || bus.bin_out !== 17'd12345) begin
      errors++;
      $display("FAIL ignore_start_result: lat=%0d bin_out=%0d, want %0d 12345",
               lat, bus.bin_out, LAT - 5);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    checks++;
    if (extra !== 0 || bus.bin_out !== 17'd12345) begin
      errors++;
      $display("FAIL ignore_start_extra_done: dones=%0d bin_out=%0d, want 0 12345",
               extra, bus.bin_out);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt, dc1, dc2;
    @(negedge clk);
    start_now(20'h00010);
    wait_done(lat, bcnt, dc1);
    checks++;
    if (bus.bin_out !== 17'd10 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: bin_out=%0d busy=%b, want 10 0", bus.bin_out, bus.busy);
    end
    start_now(20'h00100);
    wait_done(lat, bcnt, dc2);
    checks++;
    if (bus.bin_out !== 17'd100) begin
      errors++;
      $display("FAIL b2b_second: bin_out=%0d, want 100", bus.bin_out);
    end
    checks++;
    if (dc2 - dc1 !== LAT + 1) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d, want %0d", dc2 - dc1, LAT + 1);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bcnt, dc, seen;
    @(negedge clk);
    start_now(20'h54321);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bin_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_state: busy=%b done=%b bin_out=%0d, want 0 0 0",
               bus.busy, bus.done, bus.bin_out);
    end
    reset = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: active cycles=%0d, want 0", seen);
    end
    start_now(20'h00007);
    wait_done(lat, bcnt, dc);
    checks++;
    if (lat !== LAT || bus.bin_out !== 17'd7) begin
      errors++;
      $display("FAIL reset_mid_restart: lat=%0d bin_out=%0d, want %0d 7", lat, bus.bin_out, LAT);
    end
  endtask

  task automatic test_random;
    int lat, bcnt, dc;
    logic [4*DIGITS-1:0] v;
    logic [BIN_WIDTH-1:0] exp;
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      v = rand_bcd();
      exp = ref_val(v);
      start_now(v);
      wait_done(lat, bcnt, dc);
      checks++;
      if (lat !== LAT || bus.bin_out !== exp || bus.err !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d: bcd=%h lat=%0d bin_out=%0d err=%b, want %0d %0d 0",
                 n, v, lat, bus.bin_out, bus.err, LAT, exp);
      end
    end
  endtask

`ifdef BCD2BIN_DIGIT_CHECK_EN
  task automatic test_digit_check;
    int lat, bcnt, dc;
    @(negedge clk);
    start_now(20'h1A345);
    wait_done(lat, bcnt, dc);
    checks++;
    if (lat !== LAT || bus.err !== 1'b1 || bus.bin_out !== '0) begin
      errors++;
      $display("FAIL digit_check_bad: lat=%0d err=%b bin_out=%0d, want %0d 1 0",
               lat, bus.err, bus.bin_out, LAT);
    end
    @(negedge clk);
    start_now(20'h00042);
    wait_done(lat, bcnt, dc);
    checks++;
    if (bus.err !== 1'b0 || bus.bin_out !== 17'd42) begin
      errors++;
      $display("FAIL digit_check_good: err=%b bin_out=%0d, want 0 42", bus.err, bus.bin_out);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero();
    test_nines();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef BCD2BIN_DIGIT_CHECK_EN
    test_digit_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
Sequential BCD-to-binary decoder, the inverse of the BCD event counter. It takes a packed multi-digit BCD value, such as a 5-digit lag count, and produces the equivalent unsigned binary value. It uses iterative reverse double-dabble: one right shift per clock, then a subtract-3 correction on every BCD digit. It sits between the BCD counter output and any consumer that needs binary arithmetic (averaging, min/max, serial report).

Parameters:
DIGITS, 5, number of packed BCD digits on bcd_in (4 bits each, digit 0 in the LSBs).
BIN_WIDTH, 17, width of bin_out; must satisfy 2^BIN_WIDTH > 10^DIGITS - 1 (17 for 5 digits). This value is also the shift iteration count.

Ports:
clk  input  1  conversion clock; all state changes on the rising edge.
reset  input  1  reset, asynchronous, active-high.
start  input  1  request a conversion; sampled only in IDLE.
bcd_in  input  4*DIGITS  packed BCD operand; captured on the accepted start edge.
busy  output  1  high while state is not IDLE.
done  output  1  one-cycle pulse when bin_out is updated.
bin_out  output  BIN_WIDTH  binary result; holds until the next done.
err  output  1  invalid-digit flag, valid with done (see Optional Feature).

Behaviour:
- Reset (async, while reset high): state=IDLE, busy=0, done=0, bin_out=0, err=0, internal shift register and iteration counter cleared.
- Reset asserted mid-conversion: the conversion is abandoned. No done is produced, bin_out returns to 0, and the block restarts in IDLE.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k loads the working register {bcd_part=bcd_in, bin_part=0}, loads counter=BIN_WIDTH, and goes to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, one iteration per edge:
  - Shift {bcd_part, bin_part} right by 1; the LSB of bcd_part enters the MSB of bin_part.
  - Then, for every 4-bit digit of the shifted bcd_part, if digit >= 8, digit = digit - 3.
  - Decrement counter. When counter reaches 1 on this edge, go to DONE.
  - Exactly BIN_WIDTH shift edges occur (k+1 .. k+BIN_WIDTH).
- DONE (edge k+BIN_WIDTH+1):
  - bin_out <= bin_part, done=1 for this single cycle, err updated.
  - Next edge returns to IDLE.
- Latency: start accepted at edge k, done high in the cycle after edge k+BIN_WIDTH+1, i.e. 18 cycles for the defaults.
- Minimum start spacing: BIN_WIDTH+2 cycles.
- busy=1 in SHIFT and DONE; busy=0 in IDLE.
- start while busy=1 (including the DONE cycle) is ignored, with no queuing. bcd_in changes after the accepted edge have no effect.
- bin_out and err change only in DONE; between conversions they hold their last values.
- Arithmetic: unsigned. After BIN_WIDTH iterations the remaining bcd_part is zero for any valid input. It is not checked.
- Boundaries:
  - All-zero input gives 0.
  - All-nines input gives 10^DIGITS - 1 (99999 = 0x1869F for the defaults).
  - No overflow is possible when the BIN_WIDTH constraint holds.

Optional Feature:
BCD2BIN_DIGIT_CHECK_EN:
- Defined:
  - At the load edge, any bcd_in digit > 9 sets an internal invalid flag.
  - The conversion still runs the full latency.
  - In DONE, err=1 and bin_out=0.
  - For valid inputs err=0.
- Not defined:
  - err is constant 0.
  - Digits > 9 are outside the contract, the result is unspecified, and the bench must not drive them.

Test Plan:
- Reset, then start with bcd_in=0x00000 -> done after 18 cycles, bin_out=0, err=0, busy high for exactly the 18 cycles before return to IDLE.
- bcd_in=0x99999 -> bin_out=0x1869F (99999); done asserted exactly 1 cycle; bin_out held afterwards until the next done.
- bcd_in=0x12345, then start pulsed again at cycle 5 with bcd_in=0x00001 -> only one done, bin_out=0x03039 (12345); the second start is ignored.
- Back-to-back: convert 0x00010 then 0x00100, with start reasserted the cycle busy falls -> bin_out=10 then 100, dones spaced 19 cycles apart.
- Reset pulsed at cycle 9 of a 0x54321 conversion -> no done, bin_out=0, busy=0; a following start with 0x00007 gives bin_out=7.
- With BCD2BIN_DIGIT_CHECK_EN: bcd_in=0x1A345 -> done at 18 cycles with err=1, bin_out=0; next conversion of 0x00042 gives err=0, bin_out=42.
